// File: rtl/wb_unit.sv
// Registered writeback stage: MEM/WB pipeline register, load extraction and
// sign extension, a stall FSM for late load responses, and a retire counter.
module wb_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic             i_flush,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_alu,
   input  logic [XLEN-1:0]  i_csr,
   input  logic [31:0]      i_inst,
   input  logic [1:0]       i_wb_sel,
   input  logic             i_regwen,
   input  logic             i_mem_rvalid,
   input  logic [XLEN-1:0]  i_mem_rdata,
   output logic             o_stall,
   output logic [XLEN-1:0]  o_wb_data,
   output logic [4:0]       o_rd,
   output logic             o_wb_en,
   output logic             o_misalign,
   output logic [CNT_W-1:0] o_retire_cnt
);

   localparam int OFFW = $clog2(XLEN / 8);
   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t           state_q, state_d;
   logic             valid_q, valid_d;
   logic             cap_fields, cap_rdata;
   logic [XLEN-1:0]  pc_q, alu_q, csr_q, rdata_q;
   logic [4:0]       rd_q;
   logic [2:0]       funct3_q;
   logic [1:0]       sel_q;
   logic             regwen_q;
   logic [CNT_W-1:0] retire_q;
   logic [OFFW-1:0]  off;
   logic [XLEN-1:0]  shifted, load_val;
   logic             acc_mis, misalign_hit;
   logic             unused_inst_bits;

   assign unused_inst_bits = ^{i_inst[31:15], i_inst[6:0]};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
      end
   end

   // A load without a same-cycle response parks in WAIT; flush wins over a late response
   always_comb begin
      state_d    = state_q;
      valid_d    = 1'b0;
      cap_fields = 1'b0;
      cap_rdata  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!i_flush && i_valid) begin
               cap_fields = 1'b1;
               if (i_wb_sel != SEL_LOAD || i_mem_rvalid) begin
                  cap_rdata = 1'b1;
                  valid_d   = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (i_flush) begin
               state_d = IDLE;
            end else if (i_mem_rvalid) begin
               cap_rdata = 1'b1;
               valid_d   = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q     <= '0;
         alu_q    <= '0;
         csr_q    <= '0;
         rd_q     <= '0;
         funct3_q <= '0;
         sel_q    <= '0;
         regwen_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (cap_fields) begin
            pc_q     <= i_pc;
            alu_q    <= i_alu;
            csr_q    <= i_csr;
            rd_q     <= i_inst[11:7];
            funct3_q <= i_inst[14:12];
            sel_q    <= i_wb_sel;
            regwen_q <= i_regwen;
         end
         if (cap_rdata) begin
            rdata_q <= i_mem_rdata;
         end
      end
   end

   assign off     = alu_q[OFFW-1:0];
   assign shifted = rdata_q >> {off, 3'b000};

   // Wide loads only exist on 64-bit datapaths; elsewhere those encodings yield zero
   always_comb begin
      load_val = '0;
      acc_mis  = 1'b0;
      case (funct3_q)
         3'b000: load_val = XLEN'($signed(shifted[7:0]));
         3'b100: load_val = XLEN'(shifted[7:0]);
         3'b001: begin
            load_val = XLEN'($signed(shifted[15:0]));
            acc_mis  = off[0];
         end
         3'b101: begin
            load_val = XLEN'(shifted[15:0]);
            acc_mis  = off[0];
         end
         3'b010: begin
            load_val = XLEN'($signed(shifted[31:0]));
            acc_mis  = |off[1:0];
         end
         3'b110: begin
            if (XLEN == 64) begin
               load_val = XLEN'(shifted[31:0]);
               acc_mis  = |off[1:0];
            end
         end
         3'b011: begin
            if (XLEN == 64) begin
               load_val = shifted;
               acc_mis  = |off;
            end
         end
         default: load_val = '0;
      endcase
   end

   always_comb begin
      o_wb_data = csr_q;
      case (sel_q)
         SEL_ALU:  o_wb_data = alu_q;
         SEL_LOAD: o_wb_data = load_val;
         SEL_PC4:  o_wb_data = pc_q + XLEN'(4);
         default:  o_wb_data = csr_q;
      endcase
   end

   assign misalign_hit = valid_q & (sel_q == SEL_LOAD) & acc_mis;
   assign o_misalign   = misalign_hit;
   assign o_wb_en      = valid_q & regwen_q & (rd_q != 5'd0) & ~misalign_hit;
   assign o_rd         = rd_q;
   assign o_stall      = (state_q == WAIT);
   assign o_retire_cnt = retire_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         retire_q <= '0;
      end else if (valid_q && !misalign_hit) begin
         retire_q <= retire_q + CNT_W'(1);
      end
   end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Parametrised, registered successor to the combinational writeback stage. Holds a MEM/WB pipeline register and extracts and sign-extends load data by funct3 and byte offset.
- Waits for variable-latency memory load responses with a stall/flush FSM, then drives the register-file write port and a retire counter.
- Sits between the MEM stage/data memory and the register file.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CNT_W, 64, retire counter width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  MEM stage presents an instruction.
- i_flush  input  1  kill the captured or waiting instruction.
- i_pc  input  XLEN  instruction PC.
- i_alu  input  XLEN  ALU result; also the load address.
- i_csr  input  XLEN  CSR read data.
- i_inst  input  32  instruction word; rd = [11:7], funct3 = [14:12].
- i_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 CSR.
- i_regwen  input  1  instruction writes rd.
- i_mem_rvalid  input  1  load response valid.
- i_mem_rdata  input  XLEN  naturally aligned load response word.
- o_stall  output  1  upstream must hold; high iff FSM is in WAIT.
- o_wb_data  output  XLEN  writeback data.
- o_rd  output  5  destination register.
- o_wb_en  output  1  register-file write enable.
- o_misalign  output  1  one-cycle pulse: misaligned load dropped.
- o_retire_cnt  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, i_rst_n=0): FSM to IDLE; valid_q=0; all pipeline registers 0; o_wb_en=0, o_stall=0, o_misalign=0, o_wb_data=0, o_rd=0, o_retire_cnt=0.
- Latency: one cycle. An instruction captured at edge N is written back during cycle N..N+1.
- FSM IDLE, on each edge:
  - i_flush=1: valid_q<=0.
  - Else if i_valid: capture pc, alu, csr, inst, sel, regwen.
  - Non-load, or load with i_mem_rvalid=1: capture rdata, valid_q<=1.
  - Load with i_mem_rvalid=0: valid_q<=0, go to WAIT.
  - Else: valid_q<=0.
- FSM WAIT:
  - o_stall=1 and the captured fields hold.
  - i_flush has priority: go to IDLE, valid_q<=0, a same-cycle rvalid is discarded.
  - Else on i_mem_rvalid: capture rdata, valid_q<=1, go to IDLE. o_stall is still 1 in that cycle; the next instruction is accepted in the following cycle.
- Writeback mux (from registers): 00 alu_q; 01 extracted load; 10 pc_q+4, modulo 2^XLEN; 11 csr_q.
- Load extraction uses off = alu_q[log2(XLEN/8)-1:0]:
  - LB 000 / LBU 100: byte at off, sign- or zero-extended.
  - LH 001 / LHU 101: halfword at off.
  - LW 010: word.
  - XLEN=64 only: LWU 110 and LD 011.
  - Other funct3 values: extracted value is 0.
- Misalignment: off not a multiple of the access size. The load still completes the handshake, but o_wb_en=0, o_misalign=1 for that writeback cycle, and the retire counter does not increment.
- Write enable: o_wb_en = valid_q & regwen_q & (rd_q!=0) & !misalign. Writes to x0 are suppressed. o_rd = inst_q[11:7] always.
- Retire counter: increments by 1 on every cycle with valid_q=1 and no misalign, including regwen=0 instructions. Wraps modulo 2^CNT_W.
- Reset mid-WAIT: returns immediately to IDLE, o_stall drops asynchronously, and a response arriving later is ignored.

Test Plan:
- ALU op rd=5, alu=0x1234: next cycle o_wb_en=1, o_rd=5, o_wb_data=0x00001234; counter=1.
- LB, alu=0x1003, rdata=0x80FF_0000, rvalid same cycle: o_wb_data=0xFFFFFF80. LBU at the same address gives 0x00000080.
- LW with rvalid 3 cycles late: o_stall=1 for exactly 3 cycles. Data 0xDEADBEEF is written with rd intact; the next instruction is accepted the cycle after stall drops.
- LW waiting, then i_flush together with rvalid: no write, o_stall=0 next cycle, counter unchanged.
- LH at alu=0x2003: o_misalign pulses 1 cycle, o_wb_en=0. JAL pc=0xFFFF_FFFC, rd=1 gives o_wb_data=0x0. Write to rd=0 gives o_wb_en=0 and counter+1.
- i_rst_n pulsed low asynchronously during WAIT: all outputs 0 immediately. With CNT_W=4, 16 retirements wrap the counter to 0.
